ps2_keyboard: RTL and testbench

PS/2 keyboard receiver and scan-code decoder for the Hack computer. It samples the external PS/2 clock/data pair, deframes set-2 scan codes, and tracks make/break sequences. It holds the 16-bit Hack key code that the keyboard register at memory address 0x6000 exposes to the CPU. The output is the current key, or 0 when no mapped key is held.

---
 rtl/ps2_keyboard_if.sv | 9 +
 rtl/ps2_keyboard.sv | 165 ++++++++++++++++
 tb/tb_ps2_keyboard.sv | 120 ++++++++++++
 3 files changed

// File: rtl/ps2_keyboard_if.sv
// ps2_keyboard_if: PS/2 pin pair in, Hack key code and frame-error pulse out.
interface ps2_keyboard_if;
    logic        ps2_clk;
    logic        ps2_data;
    logic [15:0] key;
    logic        frame_err;
    modport master (output ps2_clk, ps2_data, input key, frame_err);
    modport slave (input ps2_clk, ps2_data, output key, frame_err);
endinterface

// File: rtl/ps2_keyboard.sv
// ps2_keyboard: PS/2 set-2 receiver and decoder producing the Hack keyboard register value.
// Define PS2_SHIFT_EN to track shift keys and map unshifted letters to lower case.
module ps2_keyboard #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input logic clk,
    input logic rst_n,
    ps2_keyboard_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    state_t state_q, state_d;
    logic [1:0] clk_sync_q, dat_sync_q;
    logic clk_prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0] bits_q, bits_d;
    logic [7:0] sr_q, sr_d;
    logic par_q, par_d, err_q, err_d;
    logic ext_q, ext_d, brk_q, brk_d;
    logic [8:0] held_q, held_d, code;
    logic [7:0] key_q, key_d, mapped, letter_base;
    logic fall, dat, tmo, accept;

    function automatic logic [7:0] map_code(input logic [8:0] c, input logic [7:0] lb);
        case (c)
            9'h01C: map_code = lb + 8'd0;   9'h032: map_code = lb + 8'd1;
            9'h021: map_code = lb + 8'd2;   9'h023: map_code = lb + 8'd3;
            9'h024: map_code = lb + 8'd4;   9'h02B: map_code = lb + 8'd5;
            9'h034: map_code = lb + 8'd6;   9'h033: map_code = lb + 8'd7;
            9'h043: map_code = lb + 8'd8;   9'h03B: map_code = lb + 8'd9;
            9'h042: map_code = lb + 8'd10;  9'h04B: map_code = lb + 8'd11;
            9'h03A: map_code = lb + 8'd12;  9'h031: map_code = lb + 8'd13;
            9'h044: map_code = lb + 8'd14;  9'h04D: map_code = lb + 8'd15;
            9'h015: map_code = lb + 8'd16;  9'h02D: map_code = lb + 8'd17;
            9'h01B: map_code = lb + 8'd18;  9'h02C: map_code = lb + 8'd19;
            9'h03C: map_code = lb + 8'd20;  9'h02A: map_code = lb + 8'd21;
            9'h01D: map_code = lb + 8'd22;  9'h022: map_code = lb + 8'd23;
            9'h035: map_code = lb + 8'd24;  9'h01A: map_code = lb + 8'd25;
            9'h045: map_code = 8'd48;       9'h016: map_code = 8'd49;
            9'h01E: map_code = 8'd50;       9'h026: map_code = 8'd51;
            9'h025: map_code = 8'd52;       9'h02E: map_code = 8'd53;
            9'h036: map_code = 8'd54;       9'h03D: map_code = 8'd55;
            9'h03E: map_code = 8'd56;       9'h046: map_code = 8'd57;
            9'h029: map_code = 8'd32;       9'h05A: map_code = 8'd128;
            9'h066: map_code = 8'd129;      9'h16B: map_code = 8'd130;
            9'h175: map_code = 8'd131;      9'h174: map_code = 8'd132;
            9'h172: map_code = 8'd133;      9'h076: map_code = 8'd140;
            default: map_code = 8'd0;
        endcase
    endfunction

    assign fall = clk_prev_q & ~clk_sync_q[1];
    assign dat = dat_sync_q[1];
    assign tmo = cnt_q == CW'(TIMEOUT_CYCLES);
    assign code = {ext_q, sr_q};
    assign mapped = map_code(code, letter_base);

    always_comb begin
        state_d = state_q;
        bits_d = bits_q;
        sr_d = sr_q;
        par_d = par_q;
        accept = 1'b0;
        err_d = 1'b0;
        cnt_d = (state_q == IDLE || fall) ? '0 : (tmo ? cnt_q : cnt_q + 1'b1);
        if (state_q != IDLE && tmo) begin
            state_d = IDLE;
            err_d = 1'b1;
        end else if (fall) begin
            case (state_q)
                IDLE: begin
                    state_d = dat ? IDLE : DATA;
                    bits_d = 3'd0;
                end
                DATA: begin
                    sr_d = {dat, sr_q[7:1]};
                    bits_d = bits_q + 3'd1;
                    state_d = (bits_q == 3'd7) ? PARITY : DATA;
                end
                PARITY: begin
                    par_d = dat;
                    state_d = STOP;
                end
                default: begin
                    accept = dat & (^{par_q, sr_q});
                    err_d = ~accept;
                    state_d = IDLE;
                end
            endcase
        end
    end

`ifdef PS2_SHIFT_EN
    logic shift_q, shift_d;
    logic is_shift;
    assign letter_base = shift_q ? 8'd65 : 8'd97;
    assign is_shift = code == 9'h012 || code == 9'h059;
    assign shift_d = (accept && is_shift) ? ~brk_q : shift_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) shift_q <= 1'b0;
        else shift_q <= shift_d;
`else
    logic is_shift;
    assign letter_base = 8'd65;
    assign is_shift = 1'b0;
`endif

    always_comb begin
        ext_d = ext_q;
        brk_d = brk_q;
        key_d = key_q;
        held_d = held_q;
        if (accept) begin
            if (sr_q == 8'hE0) ext_d = 1'b1;
            else if (sr_q == 8'hF0) brk_d = 1'b1;
            else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                if (is_shift) held_d = held_q;
                else if (brk_q) begin
                    key_d = (code == held_q) ? 8'd0 : key_q;
                    held_d = (code == held_q) ? 9'd0 : held_q;
                end else if (mapped != 8'd0) begin
                    key_d = mapped;
                    held_d = code;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_prev_q <= 1'b1;
            state_q <= IDLE;
            cnt_q <= '0;
            bits_q <= 3'd0;
            sr_q <= 8'd0;
            par_q <= 1'b0;
            err_q <= 1'b0;
            ext_q <= 1'b0;
            brk_q <= 1'b0;
            held_q <= 9'd0;
            key_q <= 8'd0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], bus.ps2_clk};
            dat_sync_q <= {dat_sync_q[0], bus.ps2_data};
            clk_prev_q <= clk_sync_q[1];
            state_q <= state_d;
            cnt_q <= cnt_d;
            bits_q <= bits_d;
            sr_q <= sr_d;
            par_q <= par_d;
            err_q <= err_d;
            ext_q <= ext_d;
            brk_q <= brk_d;
            held_q <= held_d;
            key_q <= key_d;
        end
    end

    assign bus.key = {8'h00, key_q};
    assign bus.frame_err = err_q;
endmodule

// File: tb/tb_ps2_keyboard.sv
// tb_ps2_keyboard: directed PS/2 frames with hand-computed Hack key codes.
module tb_ps2_keyboard;
    localparam int TO = 200;
`ifdef PS2_SHIFT_EN
    localparam int LB = 97;
`else
    localparam int LB = 65;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int tests = 0;
    int fails = 0;
    int err_cycles = 0;
    ps2_keyboard_if ifc ();
    ps2_keyboard #(.TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

    always #5 clk = ~clk;
    always @(negedge clk) if (ifc.frame_err === 1'b1) err_cycles++;

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic ps2_bit(input logic d);
        ifc.ps2_data = d;
        wait_clk(8);
        ifc.ps2_clk = 1'b0;
        wait_clk(8);
        ifc.ps2_clk = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(~(^b) ^ bad);
        ps2_bit(1'b1);
        wait_clk(4);
    endtask

    initial begin
        ifc.ps2_clk = 1'b1;
        ifc.ps2_data = 1'b1;
        wait_clk(3);
        chk("reset_key", int'(ifc.key), 0);
        chk("reset_err", int'(ifc.frame_err), 0);
        rst_n = 1'b1;
        wait_clk(3);
        send_byte(8'h1C, 1'b0);
        chk("make_A", int'(ifc.key), LB);
        send_byte(8'hF0, 1'b0);
        chk("f0_only", int'(ifc.key), LB);
        send_byte(8'h1C, 1'b0);
        chk("break_A", int'(ifc.key), 0);
        send_byte(8'hE0, 1'b0);
        send_byte(8'h75, 1'b0);
        chk("make_up", int'(ifc.key), 131);
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h6B, 1'b0);
        chk("break_left_other", int'(ifc.key), 131);
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h75, 1'b0);
        chk("break_up", int'(ifc.key), 0);
        chk("no_err_yet", err_cycles, 0);
        send_byte(8'h5A, 1'b1);
        chk("bad_par_err", err_cycles, 1);
        chk("bad_par_key", int'(ifc.key), 0);
        send_byte(8'h29, 1'b0);
        chk("space", int'(ifc.key), 32);
        chk("space_no_err", err_cycles, 1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        wait_clk(TO + 5);
        chk("timeout_err", err_cycles, 2);
        chk("timeout_key", int'(ifc.key), 32);
        send_byte(8'h16, 1'b0);
        chk("digit_1", int'(ifc.key), 49);
        send_byte(8'h1C, 1'b0);
        chk("make_A2", int'(ifc.key), LB);
        send_byte(8'h0D, 1'b0);
        chk("unmapped", int'(ifc.key), LB);
        send_byte(8'h32, 1'b0);
        chk("make_B", int'(ifc.key), LB + 1);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1C, 1'b0);
        chk("break_A_keeps_B", int'(ifc.key), LB + 1);
        send_byte(8'h32, 1'b0);
        chk("typematic_B", int'(ifc.key), LB + 1);
        send_byte(8'h66, 1'b0);
        chk("backspace", int'(ifc.key), 129);
        ps2_bit(1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        rst_n = 1'b0;
        #1;
        chk("async_reset_key", int'(ifc.key), 0);
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(2);
        send_byte(8'h76, 1'b0);
        chk("esc", int'(ifc.key), 140);
        chk("final_err", err_cycles, 2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
